// File: rtl/vga_pkg.sv
// Shared timing defaults, mode encodings and colour helpers
// for the VGA pattern generator.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    function automatic int total(
        input int a,
        input int b,
        input int c,
        input int d
    );
        return a + b + c + d;
    endfunction

    localparam int H_TOTAL_D = total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
    localparam int V_TOTAL_D = total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

    typedef enum logic [2:0] {
        MODE_MEM   = 3'd0,
        MODE_VBAR  = 3'd1,
        MODE_HBAR  = 3'd2,
        MODE_CHECK = 3'd3,
        MODE_BOX   = 3'd4
    } mode_e;

    // Index 0 sits in the lowest slot.
    localparam logic [7:0][11:0] PALETTE = {
        12'h000, 12'hFFF, 12'hFF0, 12'hF0F,
        12'h0FF, 12'h00F, 12'h0F0, 12'hF00
    };

    localparam logic [11:0] COL_WHITE = 12'hFFF;
    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_DBLUE = 12'h008;

    function automatic mode_e decode_mode(input logic [2:0] m);
        return (m > 3'd4) ? MODE_MEM : mode_e'(m);
    endfunction

    function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters, sync and active decode,
// and the per-line / per-frame strobes used by the pattern logic.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [9:0] o_h_addr,
    output logic [8:0] o_v_addr,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_end,
    output logic       o_v_last,
    output logic       o_v_active,
    output logic       o_frame_first,
    output logic       o_box_tick
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_act;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (o_line_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= o_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_h_act       = (r_h_cnt < H_ACT);
    assign o_v_active    = (r_v_cnt < V_ACT);
    assign o_active      = w_h_act && o_v_active;
    assign o_line_end    = (r_h_cnt == H_LAST);
    assign o_v_last      = (r_v_cnt == V_LAST);
    assign o_hsync       = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign o_vsync       = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_box_tick    = (r_h_cnt == '0) && (r_v_cnt == V_ACT);
    assign o_h_addr      = o_active ? r_h_cnt : '0;
    assign o_v_addr      = o_active ? r_v_cnt[8:0] : '0;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA source: mode latch, test-pattern generators, bouncing box
// and the stage-1 register aligned with the frame-memory latency.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_D,
    parameter int H_FP       = H_FP_D,
    parameter int H_SYNC     = H_SYNC_D,
    parameter int H_BP       = H_BP_D,
    parameter int V_ACTIVE   = V_ACTIVE_D,
    parameter int V_FP       = V_FP_D,
    parameter int V_SYNC     = V_SYNC_D,
    parameter int V_BP       = V_BP_D,
    parameter int NUM_BARS   = 4,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_mode,
    output logic [18:0] o_mem_addr,
    input  logic [11:0] i_mem_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_valid,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_frame_start
);

    localparam logic [9:0]  BAR_W_L = 10'(H_ACTIVE / NUM_BARS - 1);
    localparam logic [9:0]  BAR_H_L = 10'(V_ACTIVE / NUM_BARS - 1);
    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [8:0]  Y_MAX   = 9'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_X   = 11'(BOX_SIZE);
    localparam logic [9:0]  BOX_Y   = 10'(BOX_SIZE);

    logic [9:0]  w_h_addr;
    logic [8:0]  w_v_addr;
    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_line_end;
    logic        w_v_last;
    logic        w_v_active;
    logic        w_frame_first;
    logic        w_box_tick;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_h_addr      (w_h_addr),
        .o_v_addr      (w_v_addr),
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_line_end    (w_line_end),
        .o_v_last      (w_v_last),
        .o_v_active    (w_v_active),
        .o_frame_first (w_frame_first),
        .o_box_tick    (w_box_tick)
    );

    assign o_mem_addr = {w_h_addr, w_v_addr};

    mode_e       r_mode_q;
    mode_e       w_mode;
    logic [9:0]  r_col_cnt;
    logic [2:0]  r_col_idx;
    logic [9:0]  r_row_cnt;
    logic [2:0]  r_row_idx;
    logic [9:0]  r_box_x;
    logic [8:0]  r_box_y;
    logic        r_dx;
    logic        r_dy;

    // The frame's first pixel already uses the incoming mode.
    assign w_mode = w_frame_first ? decode_mode(i_mode) : r_mode_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode_q <= MODE_MEM;
        end else if (w_frame_first) begin
            r_mode_q <= decode_mode(i_mode);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col_cnt <= '0;
            r_col_idx <= '0;
            r_row_cnt <= '0;
            r_row_idx <= '0;
        end else begin
            if (w_line_end) begin
                r_col_cnt <= '0;
                r_col_idx <= '0;
            end else if (w_active) begin
                if (r_col_cnt == BAR_W_L) begin
                    r_col_cnt <= '0;
                    r_col_idx <= r_col_idx + 3'd1;
                end else begin
                    r_col_cnt <= r_col_cnt + 10'd1;
                end
            end
            if (w_line_end) begin
                if (w_v_last) begin
                    r_row_cnt <= '0;
                    r_row_idx <= '0;
                end else if (w_v_active) begin
                    if (r_row_cnt == BAR_H_L) begin
                        r_row_cnt <= '0;
                        r_row_idx <= r_row_idx + 3'd1;
                    end else begin
                        r_row_cnt <= r_row_cnt + 10'd1;
                    end
                end
            end
        end
    end

    // At an edge the direction flips and the box steps back inward.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_box_x <= '0;
            r_box_y <= '0;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
        end else if (w_box_tick) begin
            if (r_dx && (r_box_x == X_MAX)) begin
                r_dx    <= 1'b0;
                r_box_x <= r_box_x - 10'd1;
            end else if (!r_dx && (r_box_x == '0)) begin
                r_dx    <= 1'b1;
                r_box_x <= 10'd1;
            end else begin
                r_box_x <= r_dx ? r_box_x + 10'd1 : r_box_x - 10'd1;
            end
            if (r_dy && (r_box_y == Y_MAX)) begin
                r_dy    <= 1'b0;
                r_box_y <= r_box_y - 9'd1;
            end else if (!r_dy && (r_box_y == '0)) begin
                r_dy    <= 1'b1;
                r_box_y <= 9'd1;
            end else begin
                r_box_y <= r_dy ? r_box_y + 9'd1 : r_box_y - 9'd1;
            end
        end
    end

    logic [10:0] w_x_end;
    logic [9:0]  w_y_end;
    logic        w_in_box;
    logic        w_check;
    logic [11:0] w_pat;

    assign w_x_end  = {1'b0, r_box_x} + BOX_X;
    assign w_y_end  = {1'b0, r_box_y} + BOX_Y;
    assign w_in_box = (w_h_addr >= r_box_x) && ({1'b0, w_h_addr} < w_x_end)
                   && (w_v_addr >= r_box_y) && ({1'b0, w_v_addr} < w_y_end);
    assign w_check  = w_h_addr[CHECK_LOG2] ^ w_v_addr[CHECK_LOG2];

    always_comb begin
        w_pat = COL_BLACK;
        case (w_mode)
            MODE_VBAR:  w_pat = PALETTE[r_col_idx];
            MODE_HBAR:  w_pat = PALETTE[r_row_idx];
            MODE_CHECK: w_pat = w_check ? COL_WHITE : COL_BLACK;
            MODE_BOX:   w_pat = w_in_box ? COL_WHITE : COL_DBLUE;
            default:    w_pat = COL_BLACK;
        endcase
    end

    logic        r_hsync;
    logic        r_vsync;
    logic        r_act;
    logic        r_use_mem;
    logic        r_fs;
    logic [11:0] r_pat;
    logic [11:0] w_pix;
    logic [23:0] w_rgb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_act     <= 1'b0;
            r_use_mem <= 1'b0;
            r_fs      <= 1'b0;
            r_pat     <= '0;
        end else begin
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
            r_act     <= w_active;
            r_use_mem <= (w_mode == MODE_MEM);
            r_fs      <= w_frame_first;
            r_pat     <= w_pat;
        end
    end

    // Memory data lands in this cycle, so the mux is after the register.
    assign w_pix = r_use_mem ? i_mem_data : r_pat;
    assign w_rgb = r_act ? rgb444_to_888(w_pix) : '0;

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_valid       = r_act;
    assign o_frame_start = r_fs;
    assign o_vga_r       = w_rgb[23:16];
    assign o_vga_g       = w_rgb[15:8];
    assign o_vga_b       = w_rgb[7:0];

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA source block: owns the horizontal/vertical timing counters, drives the frame-memory read address and selects pixel colour from one of five modes (memory, vertical bars, horizontal bars, checkerboard, bouncing box). Sits between the pixel-clock generator and the DAC pins, replacing the fixed four-bar picture mux. Mode changes are frame-synchronous. All outputs are pipeline-aligned with the one-cycle memory read latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- NUM_BARS, 4, bar count for modes 1 and 2 (1..8; H_ACTIVE and V_ACTIVE divisible by it)
- CHECK_LOG2, 5, checker square side = 2^CHECK_LOG2 pixels
- BOX_SIZE, 32, bouncing-box side in pixels

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- mode  in  3  0 = memory, 1 = vertical bars, 2 = horizontal bars, 3 = checkerboard, 4 = bouncing box, 5..7 = treated as 0
- mem_addr  out  19  {h_addr[9:0], v_addr[8:0]} to the frame memory
- mem_data  in  12  RGB444 from memory, valid one clk after mem_addr
- hsync, vsync  out  1  active-low sync
- valid  out  1  high in the visible region
- vga_r, vga_g, vga_b  out  8  colour; the 4-bit nibble is replicated {n,n}
- frame_start  out  1  one-cycle pulse, aligned with the first visible pixel

## Operation
- Stage 0 timing counters: h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt advances when h_cnt wraps and itself wraps at V_TOTAL-1. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL is 525.
- Region order within a line or frame is active, front porch, sync, back porch.
- Sync is low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt.
- h_addr = h_cnt and v_addr = v_cnt inside the active region; both are 0 outside it. mem_addr is driven combinationally from stage 0.
- Mode latching: mode_q captures mode only on the cycle where h_cnt = 0 and v_cnt = 0. Mid-frame changes are ignored until the next frame.
- Mode 0: pixel = mem_data.
- Mode 1 (vertical bars):
  - Column counter counts 0..BAR_W-1 (BAR_W = H_ACTIVE/NUM_BARS).
  - bar_idx increments on each counter wrap; both clear at h_cnt = 0.
  - Colour = PALETTE[bar_idx].
- Mode 2 (horizontal bars): same scheme on lines with BAR_H = V_ACTIVE/NUM_BARS. The counter advances per line and clears at v_cnt = 0.
- Mode 3 (checkerboard): white if h_addr[CHECK_LOG2] ^ v_addr[CHECK_LOG2], else black.
- Mode 4 (bouncing box):
  - Colour is white when box_x ≤ h_addr < box_x+BOX_SIZE and box_y ≤ v_addr < box_y+BOX_SIZE; otherwise 12'h008 (dark blue).
  - Position updates once per frame, at h_cnt = 0 and v_cnt = V_ACTIVE (first blanking line).
  - x axis: if dx = +1 and box_x = H_ACTIVE-BOX_SIZE, or dx = -1 and box_x = 0, dx inverts and box_x moves one step the new way. Otherwise box_x += dx. The y axis follows the same rule.
  - Position updates in every mode, so the box keeps moving even when not displayed.
- PALETTE: index 0..7 = F00, 0F0, 00F, 0FF, F0F, FF0, FFF, 000.
- Outside the active region the colour is forced to 0.

## Timing
- Stage 1 register holds hsync, vsync, valid, pattern colour and the stage-0 "active" flag. mem_data arrives in the same cycle, so all outputs sit exactly one clk after the counters, matching memory latency.
- Colour out is stage-1 active ? selected colour : 0.
- frame_start is high in the stage-1 cycle of h_cnt = 0, v_cnt = 0.
- Reset, taking effect at the next clk edge:
  - Counters go to 0, mode_q to 0, box to (0,0) with dx = dy = +1, bar counters to 0.
  - Outputs reset to hsync = vsync = 1, valid = 0, RGB = 0, frame_start = 0.
- Reset mid-frame restarts at h_cnt = v_cnt = 0. The first output cycle after release is pixel (0,0).

## Structure
- Package vga_pkg holds the timing defaults, H_TOTAL/V_TOTAL derivation, mode encodings, PALETTE constant and the rgb444-to-rgb888 expansion function.
- Sub-module vga_timing contains the counters, sync/active decode and frame-edge strobes.
- vga_pattern_gen contains the mode latch, pattern generators, box state and stage-1 register.

## Test plan
- Reset, then run 2 frames:
  - hsync low for exactly 96 clk per line, period 800.
  - vsync low for 2 lines per frame, period 525 lines.
  - valid high for 640×480 clk per frame.
- Mode 1, NUM_BARS = 4, line 0: RGB = FF0000 for pixels 0..159, 00FF00 for 160..319, 0000FF for 320..479, 00FFFF for 480..639, 0 in blanking.
- Mode 0 with a memory model of 1-cycle latency returning data = addr[11:0]:
  - Pixel (h,v) outputs the expanded value of {h,v[8:0]}[11:0].
  - No one-pixel skew against valid.
- Mode switched 1→3 at line 200: the rest of the frame stays as bars; the next frame is a checkerboard (pixel (32,0) white, (0,0) black).
- Mode 4, 608 frames from reset: box_x steps 0→608 and then returns to 607 on frame 609. box_y bounces at 448.
- Reset asserted at h_cnt = 300, v_cnt = 100 for 1 clk:
  - Outputs go to reset values.
  - First post-reset cycle gives frame_start = 1 and pixel (0,0).
